// File: rtl/nec_prefetch_queue.sv
// Instruction prefetch queue: fetches code words at CS:fetch_ptr into an 8-byte
// ring indexed by address[2:0]; decode reads ipq[(decode_pc+N)&7] for N < ipq_len.
module nec_prefetch_queue #(
  parameter int unsigned QUEUE_SIZE = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1,
  input  logic        ce_2,
  input  logic [15:0] cs,
  input  logic [15:0] decode_pc,
  input  logic        set_pc,
  input  logic [15:0] new_pc,
  input  logic        block_prefetch,
  output logic        fetch_req,
  output logic [19:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic [7:0]  ipq [8],
  output logic [3:0]  ipq_len
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    STALE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_ptr_q, fetch_ptr_d;
  logic        fetch_req_q, fetch_req_d;
  logic [19:0] fetch_addr_q, fetch_addr_d;
  logic        fsz2_q, fsz2_d;
  logic [7:0]  ipq_q [8];
  logic [7:0]  ipq_d [8];

  logic        en;
  logic [15:0] span;
  logic [16:0] need;
  logic        room;
  logic [2:0]  slot;

  assign en = ce_1 | ce_2;

  // Room check uses the full 16-bit span; it equals ipq_len whenever
  // decode_pc trails fetch_ptr, which is the only legal case.
  always_comb begin
    span = fetch_ptr_q - decode_pc;
    need = {1'b0, span} + {15'b0, ~fetch_ptr_q[0], fetch_ptr_q[0]};
    room = (need <= 17'(QUEUE_SIZE));
    slot = fetch_ptr_q[2:0];
  end

  always_comb begin
    state_d      = state_q;
    fetch_ptr_d  = fetch_ptr_q;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    fsz2_d       = fsz2_q;
    for (int unsigned i = 0; i < 8; i++) begin
      ipq_d[i] = ipq_q[i];
    end

    if (set_pc) begin
      fetch_ptr_d = new_pc;
      // An outstanding bus cycle cannot be withdrawn; it is retired as stale.
      if (state_q != IDLE) begin
        if (fetch_ack) begin
          state_d     = IDLE;
          fetch_req_d = 1'b0;
        end else begin
          state_d = STALE;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!block_prefetch && room) begin
            state_d      = BUSY;
            fetch_req_d  = 1'b1;
            fsz2_d       = ~fetch_ptr_q[0];
            fetch_addr_d = {cs, 4'h0} + {4'h0, fetch_ptr_q[15:1], 1'b0};
          end
        end
        BUSY: begin
          if (fetch_ack) begin
            if (fsz2_q) begin
              ipq_d[slot]        = fetch_data[7:0];
              ipq_d[slot + 3'd1] = fetch_data[15:8];
            end else begin
              ipq_d[slot] = fetch_data[15:8];
            end
            fetch_ptr_d = fetch_ptr_q + {14'b0, fsz2_q, ~fsz2_q};
            state_d     = IDLE;
            fetch_req_d = 1'b0;
          end
        end
        STALE: begin
          if (fetch_ack) begin
            state_d     = IDLE;
            fetch_req_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          fetch_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_ptr_q  <= '0;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= '0;
      fsz2_q       <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        ipq_q[i] <= '0;
      end
    end else if (en) begin
      state_q      <= state_d;
      fetch_ptr_q  <= fetch_ptr_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      fsz2_q       <= fsz2_d;
      for (int unsigned i = 0; i < 8; i++) begin
        ipq_q[i] <= ipq_d[i];
      end
    end
  end

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = fetch_addr_q;
  assign ipq        = ipq_q;
  assign ipq_len    = span[3:0];

endmodule

// File: tb/tb_nec_prefetch_queue.sv
// Directed bench for nec_prefetch_queue: fill, odd target, flush, wrap,
// hold-off/consumption, clock-enable gating and reset with a request pending.
module tb_nec_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1, ce_2;
  logic [15:0] cs, decode_pc, new_pc, fetch_data;
  logic        set_pc, block_prefetch, fetch_ack;
  logic        fetch_req;
  logic [19:0] fetch_addr;
  logic [7:0]  ipq [8];
  logic [3:0]  ipq_len;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  nec_prefetch_queue #(.QUEUE_SIZE(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .ce_1           (ce_1),
    .ce_2           (ce_2),
    .cs             (cs),
    .decode_pc      (decode_pc),
    .set_pc         (set_pc),
    .new_pc         (new_pc),
    .block_prefetch (block_prefetch),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_ack      (fetch_ack),
    .fetch_data     (fetch_data),
    .ipq            (ipq),
    .ipq_len        (ipq_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue edge followed by a zero-wait ack edge.
  task automatic do_fetch(input string tag, input logic [19:0] exp_addr,
                          input logic [15:0] data, input logic [3:0] exp_len);
    tick();
    chk({tag, "_req"}, 32'(fetch_req), 32'd1);
    chk({tag, "_addr"}, 32'(fetch_addr), 32'(exp_addr));
    fetch_ack  = 1'b1;
    fetch_data = data;
    tick();
    fetch_ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(fetch_req), 32'd0);
    chk({tag, "_len"}, 32'(ipq_len), 32'(exp_len));
  endtask

  task automatic redirect(input logic [15:0] pc);
    set_pc    = 1'b1;
    new_pc    = pc;
    decode_pc = pc;
    tick();
    set_pc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce_1 = 1'b1; ce_2 = 1'b0;
    cs = '0; decode_pc = '0; new_pc = '0; fetch_data = '0;
    set_pc = 1'b0; block_prefetch = 1'b1; fetch_ack = 1'b0;
    tick();
    chk("rst_req", 32'(fetch_req), 32'd0);
    chk("rst_addr", 32'(fetch_addr), 32'd0);
    chk("rst_len", 32'(ipq_len), 32'd0);
    reset = 1'b0;
    tick();
    chk("blocked_idle", 32'(fetch_req), 32'd0);

    // Fill to QUEUE_SIZE from an even target.
    cs = 16'hF000;
    redirect(16'h0100);
    block_prefetch = 1'b0;
    do_fetch("fill0", 20'hF0100, 16'h2211, 4'd2);
    do_fetch("fill1", 20'hF0102, 16'h4433, 4'd4);
    do_fetch("fill2", 20'hF0104, 16'h6655, 4'd6);
    tick();
    chk("full_no_req", 32'(fetch_req), 32'd0);
    chk("ipq0", 32'(ipq[0]), 32'h11);
    chk("ipq5", 32'(ipq[5]), 32'h66);

    // Odd target: first fetch is the upper byte only.
    redirect(16'h0103);
    do_fetch("odd0", 20'hF0102, 16'hAB12, 4'd1);
    chk("odd_ipq3", 32'(ipq[3]), 32'hAB);
    do_fetch("odd1", 20'hF0104, 16'h7788, 4'd3);
    chk("odd_ipq4", 32'(ipq[4]), 32'h88);

    // Flush while a request is pending.
    cs = 16'h0000;
    redirect(16'h0200);
    tick();
    chk("stale_issue", 32'(fetch_req), 32'd1);
    chk("stale_issue_addr", 32'(fetch_addr), 32'h00200);
    redirect(16'h0300);
    chk("stale_req0", 32'(fetch_req), 32'd1);
    chk("stale_addr0", 32'(fetch_addr), 32'h00200);
    chk("stale_len0", 32'(ipq_len), 32'd0);
    tick();
    chk("stale_req1", 32'(fetch_req), 32'd1);
    chk("stale_addr1", 32'(fetch_addr), 32'h00200);
    fetch_ack = 1'b1; fetch_data = 16'hDEAD;
    tick();
    fetch_ack = 1'b0;
    chk("stale_drop_req", 32'(fetch_req), 32'd0);
    chk("stale_drop_len", 32'(ipq_len), 32'd0);
    chk("stale_ipq0", 32'(ipq[0]), 32'h11);
    chk("stale_ipq1", 32'(ipq[1]), 32'h22);
    tick();
    chk("after_stale_req", 32'(fetch_req), 32'd1);
    chk("after_stale_addr", 32'(fetch_addr), 32'h00300);

    // Redirect coinciding with the ack: data discarded, straight to IDLE.
    set_pc = 1'b1; new_pc = 16'h0400; decode_pc = 16'h0400;
    fetch_ack = 1'b1; fetch_data = 16'h9988;
    tick();
    set_pc = 1'b0; fetch_ack = 1'b0;
    chk("ackflush_req", 32'(fetch_req), 32'd0);
    chk("ackflush_len", 32'(ipq_len), 32'd0);
    chk("ackflush_ipq0", 32'(ipq[0]), 32'h11);
    do_fetch("post400", 20'h00400, 16'h6655, 4'd2);
    chk("post400_ipq0", 32'(ipq[0]), 32'h55);

    // 16-bit wrap of fetch_ptr.
    cs = 16'h1000;
    redirect(16'hFFFE);
    do_fetch("wrap0", 20'h1FFFE, 16'h0201, 4'd2);
    do_fetch("wrap1", 20'h10000, 16'h0403, 4'd4);
    chk("wrap_ipq7", 32'(ipq[7]), 32'h02);
    chk("wrap_ipq0", 32'(ipq[0]), 32'h03);

    // Hold-off, consumption and block_prefetch.
    do_fetch("wrap2", 20'h10002, 16'h0605, 4'd6);
    block_prefetch = 1'b1;
    decode_pc = 16'h0000;
    tick();
    chk("block_req", 32'(fetch_req), 32'd0);
    chk("block_len", 32'(ipq_len), 32'd4);
    block_prefetch = 1'b0;
    tick();
    chk("reopen_req", 32'(fetch_req), 32'd1);
    chk("reopen_addr", 32'(fetch_addr), 32'h10004);
    block_prefetch = 1'b1;
    fetch_ack = 1'b1; fetch_data = 16'h0807;
    tick();
    fetch_ack = 1'b0; block_prefetch = 1'b0;
    chk("busy_not_cancel_len", 32'(ipq_len), 32'd6);
    tick();
    chk("full_again_req", 32'(fetch_req), 32'd0);

    // Clock-enable gating.
    decode_pc = 16'h0002;
    ce_1 = 1'b0;
    tick();
    chk("ce_off_req", 32'(fetch_req), 32'd0);
    ce_2 = 1'b1;
    tick();
    chk("ce2_req", 32'(fetch_req), 32'd1);
    chk("ce2_addr", 32'(fetch_addr), 32'h10006);
    ce_2 = 1'b0;
    fetch_ack = 1'b1; fetch_data = 16'h0A09;
    tick();
    chk("ce_off_ack_req", 32'(fetch_req), 32'd1);
    chk("ce_off_ack_len", 32'(ipq_len), 32'd4);
    ce_1 = 1'b1;
    tick();
    fetch_ack = 1'b0;
    chk("ce_on_ack_req", 32'(fetch_req), 32'd0);
    chk("ce_on_ack_len", 32'(ipq_len), 32'd6);
    chk("ce_on_ack_ipq6", 32'(ipq[6]), 32'h09);

    // Asynchronous reset with a request outstanding.
    decode_pc = 16'h0004;
    tick();
    chk("pre_rst_req", 32'(fetch_req), 32'd1);
    chk("pre_rst_addr", 32'(fetch_addr), 32'h10008);
    #2;
    reset = 1'b1; decode_pc = 16'h0000; block_prefetch = 1'b1;
    #1;
    chk("async_rst_req", 32'(fetch_req), 32'd0);
    chk("async_rst_addr", 32'(fetch_addr), 32'd0);
    chk("async_rst_len", 32'(ipq_len), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_ipq%0d", i), 32'(ipq[i]), 32'd0);
    end
    reset = 1'b0;
    tick();
    chk("post_rst_req", 32'(fetch_req), 32'd0);
    chk("post_rst_len", 32'(ipq_len), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nec_prefetch_queue.md
Name: nec_prefetch_queue

Overview:
- Instruction prefetch queue for the NEC core; sits directly upstream of the decode stage.
- Fetches 16-bit code words from the bus unit at CS:fetch_ptr.
- Stores each byte in an 8-entry byte array indexed by address bits [2:0].
- Exports ipq[8] and ipq_len so decode reads byte N as ipq[(decode_pc+N)&7]; flushes and restarts on set_pc.

Parameters:
QUEUE_SIZE, 6, maximum bytes held ahead of decode_pc (legal 2..8)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous active-high reset
ce_1  input  1  phase-1 clock enable
ce_2  input  1  phase-2 clock enable
cs  input  16  code segment register
decode_pc  input  16  decode stage's current pc (consumption pointer)
set_pc  input  1  flush/redirect request (same signal decode sees)
new_pc  input  16  redirect target offset
block_prefetch  input  1  inhibit issuing new fetches
fetch_req  output  1  bus request, held until acked
fetch_addr  output  20  physical word address, bit0 always 0
fetch_ack  input  1  bus completion, fetch_data valid this cycle
fetch_data  input  16  little-endian word returned
ipq  output  8x8  byte array, slot = address[2:0]
ipq_len  output  4  valid bytes from decode_pc onward

Behaviour:
- All sequential updates occur only on an edge with (ce_1 | ce_2); otherwise state holds, including when fetch_ack is high.
- Reset (async):
  - fetch_ptr=0, state=IDLE, fetch_req=0, fetch_addr=0.
  - ipq[*]=8'h00.
  - ipq_len reads 0 (fetch_ptr and decode_pc both 0 after system reset).
- ipq_len: combinational (fetch_ptr - decode_pc) truncated to 4 bits; never exceeds QUEUE_SIZE by construction.
- Fetch size: fsz = 1 if fetch_ptr[0] else 2.
- Fetch addressing:
  - fetch_addr = ({cs,4'h0} + {4'h0, fetch_ptr[15:1],1'b0}) mod 2^20.
  - fetch_addr is registered at issue and stable while fetch_req=1.
- States:
  - IDLE: if !set_pc && !block_prefetch && (ipq_len + fsz <= QUEUE_SIZE), assert fetch_req, latch fetch_addr and fsz, go to BUSY.
  - BUSY: fetch_req=1. On fetch_ack:
    - if fsz=2: ipq[fetch_ptr[2:0]] <= data[7:0], ipq[fetch_ptr[2:0]+1] <= data[15:8], fetch_ptr += 2.
    - if fsz=1: ipq[fetch_ptr[2:0]] <= data[15:8], fetch_ptr += 1.
    - Drop fetch_req and go to IDLE. A new request cannot issue on the ack edge; the earliest next issue is the following enabled edge.
  - STALE: request in flight after a flush. fetch_req stays 1 with fetch_addr unchanged (bus protocol forbids withdrawal). On fetch_ack, discard data, leave ipq and fetch_ptr unchanged, go to IDLE.
- set_pc (highest priority):
  - fetch_ptr <= new_pc; ipq contents are don't-care.
  - From BUSY with no ack this edge, go to STALE.
  - From BUSY with ack on the same edge, discard data and go to IDLE.
  - From IDLE, no issue this edge.
  - set_pc while in STALE stays STALE.
  - ipq_len is 0 on the following cycle, since decode loads the same new_pc.
- 16-bit wrap: fetch_ptr and decode_pc wrap at 16'hFFFF→0; ipq_len subtraction is modular, so a queue spanning the wrap is correct.
- Odd target: first fetch after set_pc to an odd address is the aligned word, upper byte only (fsz=1); subsequent fetches are word-sized.
- Full: ipq_len + fsz > QUEUE_SIZE holds off issue. Decode consumption (decode_pc advance) reopens space on the next enabled edge.
- block_prefetch only suppresses issue from IDLE; it never cancels a BUSY request.
- decode_pc is never ahead of fetch_ptr; this block does not guard against that.

Test Plan:
- Reset mid-BUSY (fetch_req=1) → next cycle fetch_req=0, ipq_len=0, all ipq=0, state IDLE.
- set_pc new_pc=16'h0100, cs=16'hF000, ack every request with zero wait and decode_pc held → fetch_addr F0100, F0102, F0104; ipq_len 2,4,6; then no fourth request (QUEUE_SIZE=6).
- set_pc new_pc=16'h0103, data 16'hAB12 → ipq[3]=AB, ipq_len=1; next fetch_addr = base+0x104.
- Flush with request pending: BUSY at addr 0x0200, assert set_pc to 0x0300, ack two cycles later with 16'hDEAD → data dropped, ipq_len stays 0, fetch_req held at 0x0200 until ack, then the next request is for 0x0300.
- Wrap: new_pc=16'hFFFE, cs=16'h1000 → fetch_addr 1FFFE then 10000; ipq_len 2 then 4 across the wrap.
- Hold-off and consumption: queue full at 6, block_prefetch=1, decode_pc += 2 → no request. Drop block_prefetch → one request issues on the next enabled edge; ipq_len returns to 6 after ack.
